// File: rtl/floo_axi_sub_responder.sv
// AXI4 subordinate endpoint standing in for a fixed-latency memory tile.
// Reads return the beat address as data; accesses outside the region complete with DECERR.
module floo_axi_sub_responder #(
  parameter int unsigned           AddrWidth  = 48,
  parameter int unsigned           DataWidth  = 64,
  parameter int unsigned           IdWidth    = 4,
  parameter int unsigned           Latency    = 100,
  parameter logic [AddrWidth-1:0]  BaseAddr   = '0,
  parameter logic [AddrWidth-1:0]  RegionSize = AddrWidth'('h10000)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  aw_valid_i,
  output logic                  aw_ready_o,
  input  logic [IdWidth-1:0]    aw_id_i,
  input  logic [AddrWidth-1:0]  aw_addr_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic                  w_last_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [IdWidth-1:0]    b_id_o,
  output logic [1:0]            b_resp_o,
  input  logic                  ar_valid_i,
  output logic                  ar_ready_o,
  input  logic [IdWidth-1:0]    ar_id_i,
  input  logic [AddrWidth-1:0]  ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [2:0]            ar_size_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [IdWidth-1:0]    r_id_o,
  output logic [DataWidth-1:0]  r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic [31:0]           num_writes_o,
  output logic [31:0]           num_reads_o
);

  // One extra bit so BaseAddr+RegionSize cannot wrap past the top of the address space.
  localparam logic [AddrWidth:0] RegionLo = {1'b0, BaseAddr};
  localparam logic [AddrWidth:0] RegionHi = {1'b0, BaseAddr} + {1'b0, RegionSize};
  localparam logic [31:0]        LatCnt   = 32'(Latency);

  function automatic logic out_of_region(input logic [AddrWidth-1:0] addr);
    return ({1'b0, addr} < RegionLo) || ({1'b0, addr} >= RegionHi);
  endfunction

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_e;

  w_state_e             w_state_q, w_state_d;
  logic [31:0]          w_cnt_q, w_cnt_d;
  logic [IdWidth-1:0]   b_id_q, b_id_d;
  logic                 b_decerr_q, b_decerr_d;
  logic                 aw_ready_q, aw_ready_d;
  logic                 w_ready_q, w_ready_d;
  logic                 b_valid_q, b_valid_d;
  logic [31:0]          num_writes_q, num_writes_d;

  r_state_e             r_state_q, r_state_d;
  logic [31:0]          r_cnt_q, r_cnt_d;
  logic [IdWidth-1:0]   r_id_q, r_id_d;
  logic [AddrWidth-1:0] r_addr_q, r_addr_d;
  logic [7:0]           r_len_q, r_len_d;
  logic [2:0]           r_size_q, r_size_d;
  logic [7:0]           r_beat_q, r_beat_d;
  logic                 r_decerr_q, r_decerr_d;
  logic                 ar_ready_q, ar_ready_d;
  logic                 r_valid_q, r_valid_d;
  logic [31:0]          num_reads_q, num_reads_d;

  logic [AddrWidth-1:0] r_beat_addr;

  always_comb begin
    w_state_d    = w_state_q;
    w_cnt_d      = w_cnt_q;
    b_id_d       = b_id_q;
    b_decerr_d   = b_decerr_q;
    num_writes_d = num_writes_q;
    case (w_state_q)
      W_IDLE: if (aw_valid_i && aw_ready_q) begin
        b_id_d     = aw_id_i;
        b_decerr_d = out_of_region(aw_addr_i);
        w_state_d  = W_DATA;
      end
      W_DATA: if (w_valid_i && w_ready_q && w_last_i) begin
        w_cnt_d   = LatCnt;
        w_state_d = (LatCnt == 32'd0) ? W_RESP : W_WAIT;
      end
      // Leaving on count 1 lands b_valid exactly Latency cycles after entering the wait.
      W_WAIT: begin
        if (w_cnt_q != 32'd0) w_cnt_d = w_cnt_q - 32'd1;
        if (w_cnt_q <= 32'd1) w_state_d = W_RESP;
      end
      W_RESP: if (b_valid_q && b_ready_i) begin
        w_state_d = W_IDLE;
        if (num_writes_q != 32'hFFFF_FFFF) num_writes_d = num_writes_q + 32'd1;
      end
      default: w_state_d = W_IDLE;
    endcase
    aw_ready_d = (w_state_d == W_IDLE);
    w_ready_d  = (w_state_d == W_DATA);
    b_valid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d   = r_state_q;
    r_cnt_d     = r_cnt_q;
    r_id_d      = r_id_q;
    r_addr_d    = r_addr_q;
    r_len_d     = r_len_q;
    r_size_d    = r_size_q;
    r_beat_d    = r_beat_q;
    r_decerr_d  = r_decerr_q;
    num_reads_d = num_reads_q;
    case (r_state_q)
      R_IDLE: if (ar_valid_i && ar_ready_q) begin
        r_id_d     = ar_id_i;
        r_addr_d   = ar_addr_i;
        r_len_d    = ar_len_i;
        r_size_d   = ar_size_i;
        r_beat_d   = 8'd0;
        r_decerr_d = out_of_region(ar_addr_i);
        r_cnt_d    = LatCnt;
        r_state_d  = (LatCnt == 32'd0) ? R_BURST : R_WAIT;
      end
      R_WAIT: begin
        if (r_cnt_q != 32'd0) r_cnt_d = r_cnt_q - 32'd1;
        if (r_cnt_q <= 32'd1) r_state_d = R_BURST;
      end
      R_BURST: if (r_valid_q && r_ready_i) begin
        r_beat_d = r_beat_q + 8'd1;
        if (r_beat_q == r_len_q) begin
          r_state_d = R_IDLE;
          if (num_reads_q != 32'hFFFF_FFFF) num_reads_d = num_reads_q + 32'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    ar_ready_d = (r_state_d == R_IDLE);
    r_valid_d  = (r_state_d == R_BURST);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state_q    <= W_IDLE;
      w_cnt_q      <= '0;
      b_id_q       <= '0;
      b_decerr_q   <= 1'b0;
      aw_ready_q   <= 1'b0;
      w_ready_q    <= 1'b0;
      b_valid_q    <= 1'b0;
      num_writes_q <= '0;
      r_state_q    <= R_IDLE;
      r_cnt_q      <= '0;
      r_id_q       <= '0;
      r_addr_q     <= '0;
      r_len_q      <= '0;
      r_size_q     <= '0;
      r_beat_q     <= '0;
      r_decerr_q   <= 1'b0;
      ar_ready_q   <= 1'b0;
      r_valid_q    <= 1'b0;
      num_reads_q  <= '0;
    end else begin
      w_state_q    <= w_state_d;
      w_cnt_q      <= w_cnt_d;
      b_id_q       <= b_id_d;
      b_decerr_q   <= b_decerr_d;
      aw_ready_q   <= aw_ready_d;
      w_ready_q    <= w_ready_d;
      b_valid_q    <= b_valid_d;
      num_writes_q <= num_writes_d;
      r_state_q    <= r_state_d;
      r_cnt_q      <= r_cnt_d;
      r_id_q       <= r_id_d;
      r_addr_q     <= r_addr_d;
      r_len_q      <= r_len_d;
      r_size_q     <= r_size_d;
      r_beat_q     <= r_beat_d;
      r_decerr_q   <= r_decerr_d;
      ar_ready_q   <= ar_ready_d;
      r_valid_q    <= r_valid_d;
      num_reads_q  <= num_reads_d;
    end
  end

  assign r_beat_addr = r_addr_q + (AddrWidth'(r_beat_q) << r_size_q);

  assign aw_ready_o   = aw_ready_q;
  assign w_ready_o    = w_ready_q;
  assign b_valid_o    = b_valid_q;
  assign b_id_o       = b_id_q;
  assign b_resp_o     = (b_valid_q && b_decerr_q) ? 2'b11 : 2'b00;
  assign ar_ready_o   = ar_ready_q;
  assign r_valid_o    = r_valid_q;
  assign r_id_o       = r_id_q;
  assign r_data_o     = r_valid_q ? DataWidth'(r_beat_addr) : '0;
  assign r_resp_o     = (r_valid_q && r_decerr_q) ? 2'b11 : 2'b00;
  assign r_last_o     = r_valid_q && (r_beat_q == r_len_q);
  assign num_writes_o = num_writes_q;
  assign num_reads_o  = num_reads_q;

endmodule
